// File: rtl/sram_data_arb.sv
// Two-master arbiter for the shared data SRAM: grant, range check, one-cycle registered response.
// Define SRAM_DATA_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins) instead of round-robin.
module sram_data_arb #(
    parameter int unsigned DEPTH = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    logic        win;       // index of the master that would be granted
    logic        any_gnt;
    logic        sel_we;
    logic [29:0] sel_idx;
    logic [31:0] sel_wdata;
    logic        in_range;
    logic        issue;
    logic        rsp_live;

    logic        rsp_v_q, rsp_v_d;
    logic        rsp_m_q, rsp_m_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    // Byte-offset bits carry no information for word accesses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

`ifdef SRAM_DATA_ARB_FIXED_PRIO_EN
    always_comb begin
        win = ~m0_req_i;
    end
`else
    logic last_q, last_d;

    always_comb begin
        if (m0_req_i && m1_req_i) begin
            win = ~last_q;
        end else begin
            win = ~m0_req_i;
        end
        last_d = any_gnt ? win : last_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        any_gnt   = ~rst_i & (m0_req_i | m1_req_i);
        m0_gnt_o  = any_gnt & ~win;
        m1_gnt_o  = any_gnt & win;
        sel_we    = win ? m1_we_i : m0_we_i;
        sel_idx   = win ? m1_addr_i[31:2] : m0_addr_i[31:2];
        sel_wdata = win ? m1_wdata_i : m0_wdata_i;
        in_range  = {2'b00, sel_idx} < DEPTH;
        issue     = any_gnt & in_range;

        // Out-of-range or idle cycles leave the SRAM port fully quiet.
        mem_req_o   = issue;
        mem_we_o    = issue & sel_we;
        mem_addr_o  = issue ? {2'b00, sel_idx} : 32'h0;
        mem_wdata_o = issue ? sel_wdata : 32'h0;

        rsp_v_d    = any_gnt;
        rsp_m_d    = any_gnt ? win : rsp_m_q;
        rsp_err_d  = any_gnt & ~in_range;
        rsp_data_d = (issue && !sel_we) ? mem_rdata_i : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_v_q    <= 1'b0;
            rsp_m_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= 32'h0;
        end else begin
            rsp_v_q    <= rsp_v_d;
            rsp_m_q    <= rsp_m_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // A response pending when reset arrives is suppressed immediately.
    always_comb begin
        rsp_live    = rsp_v_q & ~rst_i;
        m0_rvalid_o = rsp_live & ~rsp_m_q;
        m1_rvalid_o = rsp_live & rsp_m_q;
        m0_err_o    = m0_rvalid_o & rsp_err_q;
        m1_err_o    = m1_rvalid_o & rsp_err_q;
        m0_rdata_o  = m0_rvalid_o ? rsp_data_q : 32'h0;
        m1_rdata_o  = m1_rvalid_o ? rsp_data_q : 32'h0;
    end

endmodule

// File: tb/tb_sram_data_arb.sv
// Bench for sram_data_arb: directed vector table, reset sequences and random traffic
// checked against a transaction-level model of arbitration, range check and SRAM contents.
module tb_sram_data_arb;

    localparam int unsigned DEPTH = 10;
    localparam int NV = 18;
`ifdef SRAM_DATA_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, load;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk = ~clk;

    sram_data_arb #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o),
        .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h0000_000F;
            3:       return 32'h0000_FF00;
            4:       return 32'h0000_000A;
            default: return 32'h1000_0000 + 32'(i);
        endcase
    endfunction

    // SRAM attached to the arbiter: combinational read, write on the clock edge.
    logic [31:0] sram [DEPTH];
    assign mem_rdata_i = (mem_addr_o < DEPTH) ? sram[mem_addr_o[3:0]] : 32'h0;
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < int'(DEPTH); i++) sram[i] <= init_word(i);
        end else if (mem_req_o && mem_we_o && mem_addr_o < DEPTH) begin
            sram[mem_addr_o[3:0]] <= mem_wdata_o;
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          m_last = 1;
    bit          p_v = 1'b0, p_err = 1'b0;
    int          p_m = 0;
    logic [31:0] p_data = 32'h0;
    bit          eg0, eg1;

    // Predict and check one cycle at the falling edge, then advance the model.
    task automatic eval_cycle();
        int              win;
        bit              any, inr, we, e_req, ev0, ev1;
        logic [31:0]     addr, wd;
        longint unsigned idx;
        @(negedge clk);
        any = !rst && (m0_req || m1_req);
        if (m0_req && m1_req) win = FIXED ? 0 : 1 - m_last;
        else win = m0_req ? 0 : 1;
        addr  = (win == 1) ? m1_addr : m0_addr;
        wd    = (win == 1) ? m1_wdata : m0_wdata;
        we    = (win == 1) ? m1_we : m0_we;
        idx   = {32'h0, addr} / 4;
        inr   = idx < DEPTH;
        eg0   = any && win == 0;
        eg1   = any && win == 1;
        e_req = any && inr;
        chk1("m0_gnt", m0_gnt_o, eg0);
        chk1("m1_gnt", m1_gnt_o, eg1);
        chk1("mem_req", mem_req_o, e_req);
        chk1("mem_we", mem_we_o, e_req && we);
        chk32("mem_addr", mem_addr_o, e_req ? 32'(idx) : 32'h0);
        chk32("mem_wdata", mem_wdata_o, e_req ? wd : 32'h0);
        ev0 = !rst && p_v && p_m == 0;
        ev1 = !rst && p_v && p_m == 1;
        chk1("m0_rvalid", m0_rvalid_o, ev0);
        chk1("m1_rvalid", m1_rvalid_o, ev1);
        chk1("m0_err", m0_err_o, ev0 && p_err);
        chk1("m1_err", m1_err_o, ev1 && p_err);
        chk32("m0_rdata", m0_rdata_o, ev0 ? p_data : 32'h0);
        chk32("m1_rdata", m1_rdata_o, ev1 ? p_data : 32'h0);
        if (rst) begin
            p_v = 1'b0; p_err = 1'b0; p_data = 32'h0; m_last = 1;
        end else begin
            p_v    = any;
            p_m    = win;
            p_err  = any && !inr;
            p_data = (any && inr && !we) ? ref_mem[int'(idx)] : 32'h0;
            if (any && inr && we) ref_mem[int'(idx)] = wd;
            if (any) m_last = win;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return (32'($urandom_range(0, DEPTH + 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mreq;
        logic [31:0] maddr;
        logic        v0, v1, err;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic mreq, input logic [31:0] maddr,
        input logic v0, input logic v1, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mreq = mreq; v.maddr = maddr;
        v.v0 = v0; v.v1 = v1; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    vec_t vt [NV];

    initial begin
        logic kw1, kpv1;
        logic [31:0] e_word;

        vt[0]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        vt[1]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0000_000F);
        vt[2]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0, 32'h0);
        vt[3]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0,
                    1'b0, 1'b1, 1'b1, 32'd9, 1'b0, 1'b1, 1'b0, 32'h0);
        vt[4]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        for (int k = 0; k < 6; k++) begin
            kw1  = !FIXED && (k % 2 == 1);
            kpv1 = !FIXED && (k % 2 == 0);
            vt[5 + k] = mk(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0,
                           !kw1, kw1, 1'b1, kw1 ? 32'd2 : 32'd1,
                           k > 0 && !kpv1, k > 0 && kpv1, 1'b0,
                           kpv1 ? 32'h1000_0002 : 32'h1000_0001);
        end
        vt[11] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'd0, FIXED, !FIXED, 1'b0,
                    FIXED ? 32'h1000_0001 : 32'h1000_0002);
        vt[12] = mk(1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        vt[13] = mk(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0);
        vt[14] = mk(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 32'h0);
        vt[15] = mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'h0000_FF00);
        vt[16] = mk(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'd9, 1'b1, 1'b0, 1'b0, 32'h0000_000A);
        vt[17] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);

        // Reset, with a request present that must not be granted.
        idle_inputs();
        rst = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        m0_req = 1'b1;
        eval_cycle();
        tick();
        m0_req = 1'b0; rst = 1'b0;
        eval_cycle();
        tick();

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            m0_req = vt[i].r0; m0_we = vt[i].w0; m0_addr = vt[i].a0; m0_wdata = vt[i].d0;
            m1_req = vt[i].r1; m1_we = vt[i].w1; m1_addr = vt[i].a1; m1_wdata = vt[i].d1;
            eval_cycle();
            chk1($sformatf("vec%0d m0_gnt", i), m0_gnt_o, vt[i].g0);
            chk1($sformatf("vec%0d m1_gnt", i), m1_gnt_o, vt[i].g1);
            chk1($sformatf("vec%0d mem_req", i), mem_req_o, vt[i].mreq);
            chk32($sformatf("vec%0d mem_addr", i), mem_addr_o, vt[i].maddr);
            chk1($sformatf("vec%0d m0_rvalid", i), m0_rvalid_o, vt[i].v0);
            chk1($sformatf("vec%0d m1_rvalid", i), m1_rvalid_o, vt[i].v1);
            chk1($sformatf("vec%0d m0_err", i), m0_err_o, vt[i].v0 & vt[i].err);
            chk1($sformatf("vec%0d m1_err", i), m1_err_o, vt[i].v1 & vt[i].err);
            chk32($sformatf("vec%0d m0_rdata", i), m0_rdata_o, vt[i].v0 ? vt[i].rdata : 32'h0);
            chk32($sformatf("vec%0d m1_rdata", i), m1_rdata_o, vt[i].v1 ? vt[i].rdata : 32'h0);
            tick();
        end

        // Only the in-range write to idx 9 may have touched the SRAM.
        for (int i = 0; i < int'(DEPTH); i++) begin
            e_word = (i == 9) ? 32'hDEAD_BEEF : init_word(i);
            chk32($sformatf("sram[%0d]", i), sram[i], e_word);
        end

        // Reset in the cycle after an m1 read grant drops its response.
        idle_inputs();
        m1_req = 1'b1; m1_addr = 32'h8;
        eval_cycle();
        chk1("rst_seq m1 granted", m1_gnt_o, 1'b1);
        tick();
        rst = 1'b1; m0_req = 1'b1; m0_addr = 32'h4;
        eval_cycle();
        chk1("rst_seq m1_rvalid in reset", m1_rvalid_o, 1'b0);
        chk1("rst_seq mem_req in reset", mem_req_o, 1'b0);
        tick();
        rst = 1'b0;
        eval_cycle();
        chk1("rst_seq m1_rvalid after reset", m1_rvalid_o, 1'b0);
        chk1("rst_seq first contention m0", m0_gnt_o, 1'b1);
        tick();
        m0_req = 1'b0;
        eval_cycle();
        tick();

        // Pointer left at master 0 must return to 1 on reset.
        idle_inputs();
        m0_req = 1'b1;
        eval_cycle();
        tick();
        m0_req = 1'b0; rst = 1'b1;
        eval_cycle();
        tick();
        rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h8;
        eval_cycle();
        chk1("rr pointer reset m0 wins", m0_gnt_o, 1'b1);
        tick();
        idle_inputs();
        eval_cycle();
        tick();

        // Random traffic; each master holds its request until granted.
        for (int c = 0; c < 400; c++) begin
            if (!m0_req && $urandom_range(0, 9) < 6) begin
                m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = rand_addr(); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 9) < 6) begin
                m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = rand_addr(); m1_wdata = $urandom;
            end
            rst = ($urandom_range(0, 99) < 2);
            eval_cycle();
            tick();
            if (eg0) m0_req = 1'b0;
            if (eg1) m1_req = 1'b0;
        end
        rst = 1'b0;
        idle_inputs();
        eval_cycle();
        tick();

        for (int i = 0; i < int'(DEPTH); i++) begin
            chk32($sformatf("final sram[%0d]", i), sram[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_data_arb.md
# sram_data_arb

Two-master arbiter sequencing the shared data SRAM between the core load/store port (master 0) and the DMA/loader port (master 1). Each cycle it grants at most one master, converts the byte address to a word index, range-checks it against the SRAM depth, and drives the SRAM's single request port. It returns registered read data or an error one cycle after the grant. It sits between the core/DMA and `sram_data`.

## Interface
- `DEPTH`, 10: number of 32-bit SRAM words; a word index ≥ DEPTH is out of range.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `m0_req_i`, `m1_req_i` in 1: request valid; master holds it and its fields stable until granted.
- `m0_we_i`, `m1_we_i` in 1: 1 = write, 0 = read.
- `m0_addr_i`, `m1_addr_i` in 32: byte address; bits [1:0] ignored.
- `m0_wdata_i`, `m1_wdata_i` in 32: write data.
- `m0_gnt_o`, `m1_gnt_o` out 1: combinational grant; request accepted this cycle.
- `m0_rvalid_o`, `m1_rvalid_o` out 1: response valid, exactly one cycle after that master's grant.
- `m0_err_o`, `m1_err_o` out 1: qualifies rvalid; the access was out of range.
- `m0_rdata_o`, `m1_rdata_o` out 32: read data, valid with rvalid for reads.
- `mem_req_o` out 1: SRAM request.
- `mem_we_o` out 1: SRAM write enable.
- `mem_addr_o` out 32: SRAM word index, `{2'b00, addr[31:2]}`.
- `mem_wdata_o` out 32: SRAM write data.
- `mem_rdata_i` in 32: SRAM combinational read data for `mem_addr_o`.

## Operation
- **Arbitration**
  - Round-robin, pointer `last_q` holding the last granted master.
  - With both requests high, the master ≠ `last_q` wins.
  - With a single request, that master wins.
  - `last_q` updates only on a grant.
- **Range check**
  - `idx = addr[31:2]`.
  - In range iff `idx < DEPTH`, using a full 30-bit compare with no truncation.
- **Grant cycle, in range**
  - `mem_req_o = 1`; `mem_we_o`, `mem_addr_o`, `mem_wdata_o` come from the winner.
- **Grant cycle, out of range**
  - Grant still issued, but `mem_req_o = 0`, so there is no SRAM side effect.
  - Response carries `err = 1`, `rdata = 0`.
- **Capture at grant edge**
  - Registers `rsp_m_q` (which master), `rsp_v_q`, `rsp_err_q`.
  - `rsp_data_q` = `mem_rdata_i` for an in-range read, else 0.
- **Response**
  - Next cycle `m{rsp_m_q}_rvalid_o = 1` with `err`/`rdata` from the registers.
  - The other master's rvalid, err and rdata are 0.
  - Writes also produce rvalid, with `rdata = 0`.
- **Back-to-back**: a new grant may occur in the same cycle as a prior response; throughput is one access per cycle.
- **Ungranted master**: sees gnt = 0 and must keep its request asserted.
- **Idle outputs**: `mem_*` outputs are 0 when there is no grant.

## Timing
- Grant: combinational, same cycle as request, with no registered stage.
- Read latency: 1 cycle, grant to rvalid.
- Write: SRAM updated at the grant edge; rvalid follows one cycle later.
- **Reset**
  - `last_q = 1`, so master 0 wins the first contention.
  - `rsp_v_q = 0`, `rsp_err_q = 0`, `rsp_data_q = 0`.
  - All gnt, rvalid, err and rdata outputs are 0, and `mem_req_o = 0`, during and after reset until a request arrives.
- **Reset mid-operation**: a pending response is dropped and no rvalid is issued after reset. Any SRAM write already issued at a prior edge stands.
- **Simultaneous requests every cycle**: strict alternation 0,1,0,1… with no starvation, since either master waits at most one cycle.
- **Boundaries**
  - `idx = DEPTH−1` is in range.
  - `idx = DEPTH` and `addr = 32'hFFFF_FFFC` are out of range.

## Configuration
- Macro `SRAM_DATA_ARB_FIXED_PRIO_EN`.
- **Defined**: fixed priority, master 0 always wins contention; `last_q` is not implemented.
- **Undefined (default)**: round-robin as above.
- All other behaviour is identical in both modes.

## Test plan
- **Single read.** After reset, m0 reads byte address 0x0 with SRAM word 0 = 0x0000_000F.
  - m0_gnt = 1 in the same cycle.
  - Next cycle m0_rvalid = 1, rdata = 0x0000_000F, err = 0.
- **Write then read.** m1 writes 0xDEAD_BEEF to 0x24 (idx 9), then reads 0x24.
  - Both are granted.
  - Read response is 0xDEAD_BEEF; write response has rdata = 0.
- **Contention.** Both masters request continuously for 6 cycles.
  - Grants go 0,1,0,1,0,1.
  - With `SRAM_DATA_ARB_FIXED_PRIO_EN`, m0 gets all 6 and m1 gnt stays 0.
- **Out of range.** m0 reads 0x28 (idx 10 = DEPTH), then writes to 0xFFFF_FFFC.
  - Both are granted with mem_req_o = 0.
  - Responses have err = 1, rdata = 0.
  - SRAM contents are unchanged.
- **Back-to-back pipelining.** m0 reads idx 3, then idx 4, on consecutive cycles.
  - rvalid stays high for 2 consecutive cycles with 0x0000_FF00, then 0x0000_000A.
- **Reset mid-operation.** Assert rst_i in the cycle after an m1 read grant.
  - No m1_rvalid is produced.
  - All outputs are 0 during reset.
  - First contention after reset is won by m0.
